// File: rtl/dtx_pkg.sv
// Shared definitions for the DTX line transmitter and the receiver-side DRU:
// framer state encoding, frame geometry and the idle line word.
package dtx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    GUARD = 2'd2
  } dtx_state_e;

  localparam int         FRAME_NIBBLES = 12;
  localparam int         FRAME_CYCLES  = 25;
  localparam int         FIFO_DEPTH    = 16;
  localparam logic [7:0] IDLE_WORD     = 8'hFF;

  // One clock carries two line bits, each repeated four times for the 8:1 serializer.
  function automatic logic [7:0] line_word(input logic b0, input logic b1);
    return {{4{b0}}, {4{b1}}};
  endfunction

endpackage

// File: rtl/dtx_if.sv
// Nibble write port of the transmitter: data, valid, and FIFO-not-full ready.
interface dtx_if;
  logic [3:0] d;
  logic       dv;
  logic       rdy;

  modport master (output d, output dv, input  rdy);
  modport slave  (input  d, input  dv, output rdy);
endinterface

// File: rtl/dtx_fifo.sv
// 16 x 4-bit nibble FIFO with occupancy count; synchronous active-high reset.
module dtx_fifo
  import dtx_pkg::*;
(
  input  logic       c,
  input  logic       r,
  input  logic       push_i,
  input  logic [3:0] wdata_i,
  input  logic       pop_i,
  output logic [3:0] rdata_o,
  output logic [4:0] count_o
);

  logic [3:0] mem_q [FIFO_DEPTH];
  logic [3:0] wptr_q;
  logic [3:0] rptr_q;
  logic [4:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  assign push_ok = push_i && (count_q < 5'(FIFO_DEPTH));
  assign pop_ok  = pop_i && (count_q != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c) begin
    if (r) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 4'd1;
      if (pop_ok)  rptr_q <= rptr_q + 4'd1;
      count_q <= count_q + {4'd0, push_ok} - {4'd0, pop_ok};
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge c) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dtx.sv
// DTX framer/serializer: 49-bit frames (start 0 + 12 nibbles) at 2 line bits per clock.
// Optional frame counter enabled by defining DTX_FRAME_COUNT_EN.
module dtx
  import dtx_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic        c,
  input  logic        r,
  dtx_if.slave        s,
  output logic [7:0]  o,
  output logic        busy,
  output logic [15:0] nframes
);

  dtx_state_e state_q, state_d;
  logic [4:0] cyc_q, cyc_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [3:0] sr_q, sr_d;
  logic [4:0] count;
  logic [3:0] head;
  logic       pop;
  logic       frame_ready;
  logic       last_cyc;
  logic       guard_done;

  dtx_fifo u_fifo (
    .c       (c),
    .r       (r),
    .push_i  (s.dv),
    .wdata_i (s.d),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign s.rdy       = (count < 5'(FIFO_DEPTH));
  assign frame_ready = (count >= 5'(FRAME_NIBBLES));
  assign last_cyc    = (cyc_q == 5'(FRAME_CYCLES));
  assign guard_done  = (gcnt_q == 4'(GUARD_CYCLES));

  always_ff @(posedge c) begin
    if (r) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      gcnt_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      gcnt_q  <= gcnt_d;
      sr_q    <= sr_d;
    end
  end

  // Leaving GUARD straight into DATA keeps back-to-back frames exactly GUARD_CYCLES apart.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    state_d = state_q;
    cyc_d   = cyc_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (frame_ready) begin
          state_d = DATA;
          cyc_d   = 5'd1;
        end
      end
      DATA: begin
        if (last_cyc) begin
          state_d = GUARD;
          gcnt_d  = 4'd1;
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      GUARD: begin
        if (guard_done) begin
          if (frame_ready) begin
            state_d = DATA;
            cyc_d   = 5'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The start bit shifts every nibble by one bit, so odd cycles straddle two nibbles.
  always_comb begin
    o    = IDLE_WORD;
    busy = 1'b0;
    pop  = 1'b0;
    sr_d = sr_q;
    if (state_q == DATA) begin
      busy = 1'b1;
      if (cyc_q == 5'd1) begin
        o    = line_word(1'b0, head[3]);
        pop  = 1'b1;
        sr_d = {head[2:0], 1'b0};
      end else if (last_cyc) begin
        o = line_word(sr_q[3], 1'b1);
      end else if (cyc_q[0]) begin
        o    = line_word(sr_q[3], head[3]);
        pop  = 1'b1;
        sr_d = {head[2:0], 1'b0};
      end else begin
        o    = line_word(sr_q[3], sr_q[2]);
        sr_d = {sr_q[1:0], 2'b00};
      end
    end else if (state_q == GUARD) begin
      busy = 1'b1;
    end
  end

`ifdef DTX_FRAME_COUNT_EN
  logic [15:0] nframes_q;

  always_ff @(posedge c) begin
    if (r) begin
      nframes_q <= '0;
    end else if (state_q == DATA && last_cyc) begin
      nframes_q <= nframes_q + 16'd1;
    end
  end

  assign nframes = nframes_q;
`else
  assign nframes = 16'h0000;
`endif

endmodule

// File: tb/tb_dtx.sv
// Self-checking bench for dtx: line-level frame model compared every cycle, plus directed literal checks.
module tb_dtx;

  logic        c;
  logic        r;
  logic [7:0]  o;
  logic        busy;
  logic [15:0] nframes;

  dtx_if bus ();

  dtx #(.GUARD_CYCLES(2)) dut (
    .c       (c),
    .r       (r),
    .s       (bus),
    .o       (o),
    .busy    (busy),
    .nframes (nframes)
  );

  localparam int G = 2;

  initial c = 1'b0;
  always #5 c = ~c;

  int n_checks = 0;
  int n_fail   = 0;
  bit saw_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line-level model ----------------
  // mk: frame cycle 1..25 currently on the line (0 = none); mg: guard cycles left incl. current.
  logic [3:0] mq[$];
  bit         fb[50];
  int         mk = 0;
  int         mg = 0;
  int         mfr = 0;
  bit         model_on = 0;

  always @(posedge c) begin
    int  cnt_pre;
    bit  pop_now, push_now, start_now;
    if (r) begin
      mq.delete();
      mk = 0;
      mg = 0;
      mfr = 0;
      model_on = 1;
    end else if (model_on) begin
      cnt_pre   = mq.size();
      pop_now   = (mk >= 1) && (mk <= 23) && (mk % 2 == 1);
      push_now  = bus.dv && (cnt_pre < 16);
      start_now = (mk == 0) && (mg <= 1) && (cnt_pre >= 12);
      if (start_now) begin
        fb[0]  = 1'b0;
        fb[49] = 1'b1;
        for (int n = 0; n < 12; n++)
          for (int b = 0; b < 4; b++)
            fb[1 + 4*n + b] = mq[n][3-b];
      end
      if (pop_now)  void'(mq.pop_front());
      if (push_now) mq.push_back(bus.d);
      if (start_now) begin
        mk = 1;
        mg = 0;
      end else if (mk == 25) begin
        mk = 0;
        mg = G;
        mfr++;
      end else if (mk > 0) begin
        mk++;
      end else if (mg > 0) begin
        mg--;
      end
    end
  end

  always @(negedge c) begin
    if (model_on) begin
      logic [7:0]  eo;
      logic [15:0] enf;
      eo = 8'hFF;
      if (mk > 0) eo = {{4{fb[2*mk-2]}}, {4{fb[2*mk-1]}}};
`ifdef DTX_FRAME_COUNT_EN
      enf = 16'(mfr);
`else
      enf = 16'h0000;
`endif
      check("model_o", {24'd0, o}, {24'd0, eo});
      check("model_busy", {31'd0, busy}, {31'd0, (mk > 0 || mg > 0)});
      check("model_rdy", {31'd0, bus.rdy}, {31'd0, (mq.size() < 16)});
      check("model_nframes", {16'd0, nframes}, {16'd0, enf});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic push_one(input logic [3:0] v);
    bit ok;
    bus.d  = v;
    bus.dv = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ok = bus.rdy;
      if (!ok) saw_full = 1;
      tick();
      if (ok) break;
    end
  endtask

  task automatic wait_start(input int bound, output bit found);
    found = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge c);
      if (o != 8'hFF) begin
        found = 1;
        break;
      end
    end
    check("frame_start_seen", {31'd0, found}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit         found;
    int         busy_n;
    int         gap;
    logic [7:0] w[25];
    bit         lb[50];
    logic [3:0] nib;

    r = 1'b1;
    bus.dv = 1'b0;
    bus.d  = 4'h0;
    repeat (3) tick();
    @(negedge c);
    check("rst_o", {24'd0, o}, 32'h0000_00FF);
    check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_nframes", {16'd0, nframes}, 32'd0);
    r = 1'b0;
    tick();

    // 12 x 0xA: every frame word is 0F, busy for 25 + 2 cycles.
    for (int i = 0; i < 12; i++) push_one(4'hA);
    bus.dv = 1'b0;
    @(negedge c);
    check("a_pre_start", {24'd0, o}, 32'h0000_00FF);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge c);
      if (i < 25) check("a_word", {24'd0, o}, 32'h0000_000F);
      if (i == 25 || i == 26) check("a_guard_word", {24'd0, o}, 32'h0000_00FF);
      busy_n += int'(busy);
    end
    check("a_busy_cycles", busy_n, 32'd27);

    // 11 nibbles sit; the 12th starts a frame one cycle after the count is seen.
    push_one(4'hC);
    for (int i = 1; i < 11; i++) push_one(4'(i));
    bus.dv = 1'b0;
    repeat (30) tick();
    @(negedge c);
    check("b_11_idle_o", {24'd0, o}, 32'h0000_00FF);
    check("b_11_idle_busy", {31'd0, busy}, 32'd0);
    push_one(4'h7);
    bus.dv = 1'b0;
    @(negedge c);
    check("b_observe_cycle_o", {24'd0, o}, 32'h0000_00FF);
    tick();
    @(negedge c);
    check("b_first_word", {24'd0, o}, 32'h0000_000F);
    repeat (30) tick();

    // 24 nibbles streamed: two frames separated by exactly G idle words.
    saw_full = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) push_one(4'(i));
        bus.dv = 1'b0;
      end
      begin
        wait_start(40, found);
        repeat (25) @(negedge c);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
          if (o != 8'hFF) break;
          gap++;
          @(negedge c);
        end
        check("c_gap_words", gap, G);
      end
    join
    check("c_rdy_dropped", {31'd0, saw_full}, 32'd1);
    repeat (60) tick();
    @(negedge c);
    check("c_rdy_recovered", {31'd0, bus.rdy}, 32'd1);
    check("c_idle_after", {31'd0, busy}, 32'd0);

    // Reset at frame cycle 10 aborts; nibbles offered during reset are dropped.
    for (int i = 0; i < 12; i++) push_one(4'h3);
    bus.dv = 1'b0;
    wait_start(10, found);
    repeat (9) tick();
    r = 1'b1;
    bus.dv = 1'b1;
    bus.d  = 4'h5;
    tick();
    @(negedge c);
    check("d_rst_o", {24'd0, o}, 32'h0000_00FF);
    check("d_rst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("d_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    r = 1'b0;
    bus.dv = 1'b0;
    repeat (40) tick();
    @(negedge c);
    check("d_no_resume_busy", {31'd0, busy}, 32'd0);
    check("d_no_resume_o", {24'd0, o}, 32'h0000_00FF);

    // Loopback decode of 0x1..0xC straight from the line words.
    for (int i = 1; i <= 12; i++) push_one(4'(i));
    bus.dv = 1'b0;
    wait_start(10, found);
    w[0] = o;
    for (int i = 1; i < 25; i++) begin
      @(negedge c);
      w[i] = o;
    end
    for (int i = 0; i < 25; i++) begin
      lb[2*i]   = w[i][7];
      lb[2*i+1] = w[i][3];
    end
    check("e_start_bit", {31'd0, lb[0]}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      nib = {lb[4*k+1], lb[4*k+2], lb[4*k+3], lb[4*k+4]};
      check((k == 11) ? "e_rx_last" : "e_rx_nibble", {28'd0, nib}, 32'(k + 1));
    end
    check("e_trailing_idle", {31'd0, lb[49]}, 32'd1);
    repeat (10) tick();
    @(negedge c);
`ifdef DTX_FRAME_COUNT_EN
    check("e_nframes", {16'd0, nframes}, 32'd1);
`else
    check("e_nframes", {16'd0, nframes}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
